// File: rtl/ysyx_23060201_mem_arb_pkg.sv
// ============================================================================
// ysyx_23060201_mem_arb_pkg : shared FSM state and grant-id encodings
// Rev 1.0
// ============================================================================
`default_nettype none

package ysyx_23060201_mem_arb_pkg;

  typedef enum logic [1:0] {
    ARB_IDLE  = 2'd0,
    ARB_ISSUE = 2'd1,
    ARB_WAIT  = 2'd2
  } arb_state_e;

  typedef enum logic [1:0] {
    GNT_NONE = 2'd0,
    GNT_IFU  = 2'd1,
    GNT_LSU  = 2'd2
  } gnt_e;

endpackage

`default_nettype wire

// File: rtl/ysyx_23060201_mem_arb_if.sv
// ============================================================================
// ysyx_23060201_mem_arb_if : IFU, LSU and memory-port handshake bundle
// Rev 1.0
// ============================================================================
`default_nettype none

interface ysyx_23060201_mem_arb_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int MASK_WIDTH = 8
);
  logic                  ifu_req_valid;
  logic                  ifu_req_ready;
  logic [ADDR_WIDTH-1:0] ifu_req_addr;
  logic                  ifu_resp_valid;
  logic [DATA_WIDTH-1:0] ifu_resp_rdata;

  logic                  lsu_req_valid;
  logic                  lsu_req_ready;
  logic                  lsu_req_wen;
  logic [ADDR_WIDTH-1:0] lsu_req_addr;
  logic [DATA_WIDTH-1:0] lsu_req_wdata;
  logic [MASK_WIDTH-1:0] lsu_req_wmask;
  logic                  lsu_resp_valid;
  logic [DATA_WIDTH-1:0] lsu_resp_rdata;

  logic                  mem_req_valid;
  logic                  mem_req_ready;
  logic                  mem_req_wen;
  logic [ADDR_WIDTH-1:0] mem_req_addr;
  logic [DATA_WIDTH-1:0] mem_req_wdata;
  logic [MASK_WIDTH-1:0] mem_req_wmask;
  logic                  mem_resp_valid;
  logic [DATA_WIDTH-1:0] mem_resp_rdata;

  // master: the arbiter (serves IFU/LSU, masters the memory port)
  modport master (
    input  ifu_req_valid, ifu_req_addr,
    output ifu_req_ready, ifu_resp_valid, ifu_resp_rdata,
    input  lsu_req_valid, lsu_req_wen, lsu_req_addr, lsu_req_wdata, lsu_req_wmask,
    output lsu_req_ready, lsu_resp_valid, lsu_resp_rdata,
    output mem_req_valid, mem_req_wen, mem_req_addr, mem_req_wdata, mem_req_wmask,
    input  mem_req_ready, mem_resp_valid, mem_resp_rdata
  );

  // slave: the environment (requesters plus memory model)
  modport slave (
    output ifu_req_valid, ifu_req_addr,
    input  ifu_req_ready, ifu_resp_valid, ifu_resp_rdata,
    output lsu_req_valid, lsu_req_wen, lsu_req_addr, lsu_req_wdata, lsu_req_wmask,
    input  lsu_req_ready, lsu_resp_valid, lsu_resp_rdata,
    input  mem_req_valid, mem_req_wen, mem_req_addr, mem_req_wdata, mem_req_wmask,
    output mem_req_ready, mem_resp_valid, mem_resp_rdata
  );

endinterface

`default_nettype wire

// File: rtl/ysyx_23060201_arb_sel.sv
// ============================================================================
// ysyx_23060201_arb_sel : two-way requester selector (LSU > IFU, or
// round-robin on ties when YSYX_23060201_ARB_RR_EN is defined)
// Rev 1.0
// ============================================================================
`default_nettype none

module ysyx_23060201_arb_sel
  import ysyx_23060201_mem_arb_pkg::*;
(
  input  logic ifu_valid_i,
  input  logic lsu_valid_i,
`ifdef YSYX_23060201_ARB_RR_EN
  input  gnt_e last_gnt_i,
`endif
  output gnt_e gnt_o
);

  always_comb begin
    gnt_o = GNT_NONE;
    if (lsu_valid_i && ifu_valid_i) begin
`ifdef YSYX_23060201_ARB_RR_EN
      gnt_o = (last_gnt_i == GNT_LSU) ? GNT_IFU : GNT_LSU;
`else
      gnt_o = GNT_LSU;
`endif
    end else if (lsu_valid_i) begin
      gnt_o = GNT_LSU;
    end else if (ifu_valid_i) begin
      gnt_o = GNT_IFU;
    end
  end

endmodule

`default_nettype wire

// File: rtl/ysyx_23060201_mem_arb.sv
// ============================================================================
// ysyx_23060201_mem_arb : IFU/LSU arbiter for the single data-memory port,
// one outstanding transaction. Option macro: YSYX_23060201_ARB_RR_EN
// Rev 1.0
// ============================================================================
`default_nettype none

module ysyx_23060201_mem_arb
  import ysyx_23060201_mem_arb_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int MASK_WIDTH = 8
) (
  input  logic                          clk,
  input  logic                          rst,
  ysyx_23060201_mem_arb_if.master       bus,
  output logic                          arb_err
);

  arb_state_e            state_q;
  gnt_e                  gnt_q;
  gnt_e                  gnt_d;
  logic                  mem_valid_q;
  logic                  wen_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [DATA_WIDTH-1:0] wdata_q;
  logic [MASK_WIDTH-1:0] wmask_q;
  logic                  err_q;
  logic                  resp_fire;

`ifdef YSYX_23060201_ARB_RR_EN
  gnt_e                  last_gnt_q;
`endif

  ysyx_23060201_arb_sel u_sel (
    .ifu_valid_i (bus.ifu_req_valid),
    .lsu_valid_i (bus.lsu_req_valid),
`ifdef YSYX_23060201_ARB_RR_EN
    .last_gnt_i  (last_gnt_q),
`endif
    .gnt_o       (gnt_d)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ARB_IDLE;
      gnt_q       <= GNT_NONE;
      mem_valid_q <= 1'b0;
      wen_q       <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      wmask_q     <= '0;
      err_q       <= 1'b0;
`ifdef YSYX_23060201_ARB_RR_EN
      last_gnt_q  <= GNT_IFU;
`endif
    end else begin
      if (bus.mem_resp_valid && (state_q != ARB_WAIT)) begin
        err_q <= 1'b1;
      end
      case (state_q)
        ARB_IDLE: begin
          if (gnt_d != GNT_NONE) begin
            state_q     <= ARB_ISSUE;
            gnt_q       <= gnt_d;
            mem_valid_q <= 1'b1;
`ifdef YSYX_23060201_ARB_RR_EN
            last_gnt_q  <= gnt_d;
`endif
            if (gnt_d == GNT_LSU) begin
              wen_q   <= bus.lsu_req_wen;
              addr_q  <= bus.lsu_req_addr;
              wdata_q <= bus.lsu_req_wdata;
              wmask_q <= bus.lsu_req_wmask;
            end else begin
              // Instruction fetches are always plain reads
              wen_q   <= 1'b0;
              addr_q  <= bus.ifu_req_addr;
              wdata_q <= '0;
              wmask_q <= '0;
            end
          end
        end
        ARB_ISSUE: begin
          if (bus.mem_req_ready) begin
            state_q     <= ARB_WAIT;
            mem_valid_q <= 1'b0;
          end
        end
        ARB_WAIT: begin
          if (bus.mem_resp_valid) begin
            state_q <= ARB_IDLE;
            gnt_q   <= GNT_NONE;
          end
        end
        default: begin
          state_q     <= ARB_IDLE;
          gnt_q       <= GNT_NONE;
          mem_valid_q <= 1'b0;
        end
      endcase
    end
  end

  // Ready is gated by rst so outputs drop the instant reset asserts
  assign bus.ifu_req_ready  = !rst && (state_q == ARB_IDLE) && (gnt_d == GNT_IFU);
  assign bus.lsu_req_ready  = !rst && (state_q == ARB_IDLE) && (gnt_d == GNT_LSU);

  assign resp_fire          = (state_q == ARB_WAIT) && bus.mem_resp_valid;
  assign bus.ifu_resp_valid = resp_fire && (gnt_q == GNT_IFU);
  assign bus.lsu_resp_valid = resp_fire && (gnt_q == GNT_LSU);
  assign bus.ifu_resp_rdata = bus.ifu_resp_valid ? bus.mem_resp_rdata : '0;
  assign bus.lsu_resp_rdata = (bus.lsu_resp_valid && !wen_q) ? bus.mem_resp_rdata : '0;

  assign bus.mem_req_valid  = mem_valid_q;
  assign bus.mem_req_wen    = wen_q;
  assign bus.mem_req_addr   = addr_q;
  assign bus.mem_req_wdata  = wdata_q;
  assign bus.mem_req_wmask  = wmask_q;

  assign arb_err            = err_q;

endmodule

`default_nettype wire

// File: doc/ysyx_23060201_mem_arb.md
Name: ysyx_23060201_mem_arb

Overview:
Two-requester arbiter that shares the single data-memory port (DPI-backed pmem read/write) between the IFU (read-only instruction fetch) and the LSU (load/store).
- Accepts one request at a time, registers it, issues it to memory, waits for the memory response and routes it back to the granted requester.
- Sits between IFU/LSU and the memory model; exactly one transaction is outstanding.

Parameters:
- ADDR_WIDTH, 32, address width of all request ports.
- DATA_WIDTH, 32, read/write data width.
- MASK_WIDTH, 8, byte write-mask width, matching the pmem_write mask byte.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- ifu_req_valid  in  1  IFU read request.
- ifu_req_ready  out  1  IFU request accepted this cycle.
- ifu_req_addr  in  ADDR_WIDTH  fetch address.
- ifu_resp_valid  out  1  IFU read data valid; one-cycle pulse.
- ifu_resp_rdata  out  DATA_WIDTH  fetched word.
- lsu_req_valid  in  1  LSU request.
- lsu_req_ready  out  1  LSU request accepted this cycle.
- lsu_req_wen  in  1  1 = write, 0 = read.
- lsu_req_addr  in  ADDR_WIDTH  access address.
- lsu_req_wdata  in  DATA_WIDTH  store data.
- lsu_req_wmask  in  MASK_WIDTH  store byte mask.
- lsu_resp_valid  out  1  LSU response; one-cycle pulse, also for writes.
- lsu_resp_rdata  out  DATA_WIDTH  load data; 0 for writes.
- mem_req_valid  out  1  request to memory.
- mem_req_ready  in  1  memory accepts the request.
- mem_req_wen  out  1  write enable.
- mem_req_addr  out  ADDR_WIDTH  address.
- mem_req_wdata  out  DATA_WIDTH  write data.
- mem_req_wmask  out  MASK_WIDTH  write mask.
- mem_resp_valid  in  1  memory response.
- mem_resp_rdata  in  DATA_WIDTH  memory read data.

Behaviour:
- Reset (asynchronous, takes effect immediately):
  - State goes to IDLE; grant register goes to NONE.
  - All outputs go to 0.
  - Any in-flight transaction is dropped, and no response is delivered for it.
- FSM states: IDLE, ISSUE, WAIT.
- IDLE:
  - If any request is valid, select the winner and assert its *_req_ready combinationally in the same cycle.
  - On the clock edge, latch the winner's wen/addr/wdata/wmask and the grant id, then go to ISSUE.
  - For IFU grants, the latched wen = 0 and wmask = 0.
  - The loser's ready stays 0, and it must hold its request.
- Selection: fixed priority, LSU over IFU.
- ISSUE:
  - mem_req_valid = 1 with the latched fields, held stable until mem_req_ready.
  - On mem_req_valid && mem_req_ready, go to WAIT.
- WAIT:
  - On mem_resp_valid, assert the granted requester's *_resp_valid for that cycle only.
  - *_resp_rdata = mem_resp_rdata combinationally for reads; lsu_resp_rdata = 0 for writes.
  - Go to IDLE the same edge. Requesters must accept responses; there is no response backpressure.
- Both *_req_ready are 0 outside IDLE.
- Minimum latency is 3 cycles from acceptance to response: accept (IDLE), issue with mem_req_ready=1 (ISSUE), response (WAIT).
- Back-to-back: a new request can be accepted the cycle after the response.
- mem_resp_valid in IDLE or ISSUE is ignored, and the error flag is set (see Optional Feature).
- mem_req_ready in IDLE or WAIT is ignored.
- Requests that deassert valid before ready are not latched.
- *_resp_valid outputs are mutually exclusive and never both 1.

Optional Feature:
- Macro: YSYX_23060201_ARB_RR_EN.
- Defined:
  - Round-robin selection when both requesters are valid in IDLE: the requester not granted most recently wins.
  - A last-grant register (reset value IFU, so LSU wins the first tie) updates on each acceptance.
  - A single valid requester always wins.
- Undefined: fixed priority LSU > IFU, with no last-grant register.
- Independently of the macro, the spurious-response error output is always present:
  - arb_err  out  1  sticky, set by mem_resp_valid outside WAIT, cleared only by rst.

Decomposition:
- Shared header defines.v holds:
  - FSM state encodings: ARB_IDLE=2'd0, ARB_ISSUE=2'd1, ARB_WAIT=2'd2.
  - Grant ids: GNT_NONE, GNT_IFU, GNT_LSU.
- One natural sub-module: ysyx_23060201_arb_sel.
  - Combinational two-way selector taking both valids and last_grant, returning the grant id.
  - Holds the fixed/round-robin choice under the macro.

Test Plan:
- Single IFU read: ifu_req_valid=1, addr=0x80000000 in IDLE, memory ready immediately and responds next cycle with 0x00000413.
  - Expect ifu_req_ready high in cycle 0.
  - Expect mem_req_valid in cycle 1 with wen=0 and wmask=0.
  - Expect ifu_resp_valid in cycle 2 with rdata=0x00000413.
- LSU write: wen=1, addr=0x80000004, wdata=0xDEADBEEF, wmask=0x0F.
  - Expect mem_req fields to match exactly.
  - Expect lsu_resp_valid pulse with rdata=0; ifu_resp_valid stays 0.
- Simultaneous requests, fixed priority:
  - LSU is granted first; IFU is held and granted on the next IDLE.
  - With the macro defined, three consecutive ties alternate LSU, IFU, LSU.
- Memory backpressure: mem_req_ready=0 for 4 cycles.
  - Expect mem_req_valid and all mem_req fields stable across those cycles.
  - Expect both req_ready outputs 0 throughout.
- Reset mid-operation: assert rst in WAIT.
  - Expect all outputs 0 immediately and state IDLE.
  - A later mem_resp_valid produces no *_resp_valid and sets arb_err=1.
